pt_check: RTL and testbench

PT_CHECK -- requirements
Module: pt_check

---
 rtl/pt_check.sv | 96 +++++++++
 tb/tb_pt_check.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pt_check.sv
// Plaintext validity checker: reads a length-prefixed message from a synchronous-read
// memory and reports whether every message byte is printable ASCII (0x20..0x7E).
module pt_check (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       ok,
  output logic [7:0] msg_len,
  output logic [7:0] bad_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_ADDR,
    LEN_READ,
    BYTE_ADDR,
    BYTE_READ
  } state_t;

  state_t     state, state_n;
  logic [7:0] addr_n;
  logic       ok_n;
  logic [7:0] len_n;
  logic [7:0] bad_n;
  logic       byte_pass;

  assign rdy       = (state == IDLE);
  assign byte_pass = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pt_addr <= 8'd0;
      ok      <= 1'b0;
      msg_len <= 8'd0;
      bad_idx <= 8'd0;
    end else begin
      state   <= state_n;
      pt_addr <= addr_n;
      ok      <= ok_n;
      msg_len <= len_n;
      bad_idx <= bad_n;
    end
  end

  // The last-index test compares before incrementing, so L=255 stops at address 255.
  always_comb begin
    state_n = state;
    addr_n  = pt_addr;
    ok_n    = ok;
    len_n   = msg_len;
    bad_n   = bad_idx;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = LEN_ADDR;
          addr_n  = 8'd0;
          ok_n    = 1'b0;
          len_n   = 8'd0;
          bad_n   = 8'd0;
        end
      end
      LEN_ADDR: state_n = LEN_READ;
      LEN_READ: begin
        len_n = pt_rddata;
        if (pt_rddata == 8'd0) begin
          ok_n    = 1'b1;
          state_n = IDLE;
        end else begin
          addr_n  = 8'd1;
          state_n = BYTE_ADDR;
        end
      end
      BYTE_ADDR: state_n = BYTE_READ;
      BYTE_READ: begin
        if (!byte_pass) begin
          ok_n    = 1'b0;
          bad_n   = pt_addr;
          state_n = IDLE;
        end else if (pt_addr == msg_len) begin
          ok_n    = 1'b1;
          bad_n   = 8'd0;
          state_n = IDLE;
        end else begin
          addr_n  = pt_addr + 8'd1;
          state_n = BYTE_ADDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pt_check.sv
// Bench for pt_check: directed vector table, reset corner cases and random messages
// compared against a plain loop-based reference of the message rule.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       ok;
  logic [7:0] msg_len;
  logic [7:0] bad_idx;

  logic [7:0] mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  len;
    logic [39:0] body;
    logic [7:0]  fill;
    bit          hold;
    logic        exp_ok;
    logic [7:0]  exp_bad;
    logic [7:0]  exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  pt_check dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .ok       (ok),
    .msg_len  (msg_len),
    .bad_idx  (bad_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadMem(input logic [7:0] len, input logic [39:0] body, input logic [7:0] fill);
    mem[0] = len;
    for (int i = 1; i < 256; i++)
      mem[i] = (i <= 5) ? body[8*(i-1) +: 8] : fill;
  endtask

  // Reference: walk the message bytes in order and stop at the first non-printable one.
  function automatic void refModel(output logic eok, output logic [7:0] ebad,
                                   output logic [7:0] eaddr, output int elat);
    int l;
    l     = int'(mem[0]);
    eok   = 1'b1;
    ebad  = 8'd0;
    eaddr = mem[0];
    elat  = 2 + 2 * l;
    for (int i = 1; i <= l; i++) begin
      if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
        eok   = 1'b0;
        ebad  = 8'(i);
        eaddr = 8'(i);
        elat  = 2 + 2 * i;
        break;
      end
    end
  endfunction

  task automatic applyStimulus(input bit hold, output int lat, output bit seq_ok, output bit timed_out);
    logic [7:0] last;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) en = 1'b0;
    last      = pt_addr;
    seq_ok    = (pt_addr == 8'd0) && !rdy;
    lat       = 0;
    timed_out = 1'b0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (pt_addr != last) begin
        if (pt_addr != last + 8'd1) seq_ok = 1'b0;
        last = pt_addr;
      end
      if (rdy) break;
      if (lat >= 600) begin
        timed_out = 1'b1;
        break;
      end
    end
    en = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input bit hold, input logic eok, input logic [7:0] elen,
                             input logic [7:0] ebad, input logic [7:0] eaddr, input int elat);
    int lat;
    bit seq_ok;
    bit to;
    applyStimulus(hold, lat, seq_ok, to);
    checkOutput({tag, " timeout"}, 32'(to), 32'd0);
    checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
    checkOutput({tag, " ok"}, 32'(ok), 32'(eok));
    checkOutput({tag, " msg_len"}, 32'(msg_len), 32'(elen));
    checkOutput({tag, " bad_idx"}, 32'(bad_idx), 32'(ebad));
    checkOutput({tag, " final_addr"}, 32'(pt_addr), 32'(eaddr));
    checkOutput({tag, " addr_seq"}, 32'(seq_ok), 32'd1);
  endtask

  initial begin
    logic       eok;
    logic [7:0] ebad, eaddr;
    int         elat;
    logic [7:0] rl;

    vecs[0] = '{8'h03, 40'h00_00_21_69_48, 8'h00, 1'b0, 1'b1, 8'h00, 8'h03, 8};
    vecs[1] = '{8'h04, 40'h00_41_41_1F_41, 8'h00, 1'b0, 1'b0, 8'h02, 8'h02, 6};
    vecs[2] = '{8'h03, 40'h00_00_7F_7E_20, 8'h00, 1'b0, 1'b0, 8'h03, 8'h03, 8};
    vecs[3] = '{8'h02, 40'h00_00_7F_7E_20, 8'h00, 1'b0, 1'b1, 8'h00, 8'h02, 6};
    vecs[4] = '{8'h00, 40'h00_00_00_00_00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 2};
    vecs[5] = '{8'hFF, 40'h41_41_41_41_41, 8'h41, 1'b0, 1'b1, 8'h00, 8'hFF, 512};
    vecs[6] = '{8'h05, 40'h41_41_41_41_00, 8'h41, 1'b1, 1'b0, 8'h01, 8'h01, 4};
    vecs[7] = '{8'h01, 40'h00_00_00_00_FF, 8'h00, 1'b0, 1'b0, 8'h01, 8'h01, 4};
    vecs[8] = '{8'h01, 40'h00_00_00_7F_7E, 8'h00, 1'b1, 1'b1, 8'h00, 8'h01, 4};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset rdy", 32'(rdy), 32'd1);
    checkOutput("reset ok", 32'(ok), 32'd0);
    checkOutput("reset msg_len", 32'(msg_len), 32'd0);
    checkOutput("reset bad_idx", 32'(bad_idx), 32'd0);
    checkOutput("reset pt_addr", 32'(pt_addr), 32'd0);

    for (int v = 0; v < 9; v++) begin
      loadMem(vecs[v].len, vecs[v].body, vecs[v].fill);
      runAndCheck($sformatf("vec%0d", v), vecs[v].hold, vecs[v].exp_ok, vecs[v].len,
                  vecs[v].exp_bad, vecs[v].exp_addr, vecs[v].exp_lat);
    end

    // Reset during BYTE_READ of a valid scan abandons it.
    loadMem(8'h03, 40'h00_00_21_69_48, 8'h00);
    runAndCheck("pre_reset", 1'b0, 1'b1, 8'h03, 8'h00, 8'h03, 8);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midscan busy", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midscan rdy", 32'(rdy), 32'd1);
    checkOutput("midscan ok", 32'(ok), 32'd0);
    checkOutput("midscan msg_len", 32'(msg_len), 32'd0);
    checkOutput("midscan pt_addr", 32'(pt_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midscan stays idle", 32'(rdy), 32'd1);

    // rst and en together: reset wins, no scan starts.
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    checkOutput("rst_prio rdy", 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_prio still idle", 32'(rdy), 32'd1);
    checkOutput("rst_prio ok", 32'(ok), 32'd0);

    for (int r = 0; r < 25; r++) begin
      rl = 8'($urandom_range(0, 24));
      mem[0] = rl;
      for (int i = 1; i < 256; i++) begin
        if ($urandom_range(0, 14) == 0) mem[i] = 8'($urandom_range(0, 255));
        else                            mem[i] = 8'($urandom_range(32, 126));
      end
      refModel(eok, ebad, eaddr, elat);
      runAndCheck($sformatf("rand%0d", r), bit'($urandom_range(0, 1)), eok, rl, ebad, eaddr, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
